// File: rtl/load_store_unit.sv
// Load/store unit between the ALU and a byte-enabled, word-addressed data memory.
// It aligns stores into byte lanes, extends loads, and stalls the core until each access completes.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  stall,
    output logic                  done,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            off_q;
    logic                  fault_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  illegal;
    logic                  misaligned;
    logic                  dec_fault;
    logic [3:0]            be_dec;
    logic [DATA_WIDTH-1:0] wdata_dec;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] load_ext;

    // funct3[1:0] is the access size (00 byte, 01 half, 10 word); funct3[2] selects zero-extension.
    always_comb begin
        illegal    = (funct3[1:0] == 2'b11) || (funct3[2] && (funct3[1] || req_we));
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        dec_fault  = illegal || misaligned;
        case (funct3[1:0])
            2'b00: begin
                be_dec    = 4'b0001 << addr[1:0];
                wdata_dec = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_dec    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{wdata[15:0]}};
            end
            default: begin
                be_dec    = 4'b1111;
                wdata_dec = wdata;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_ext = uns_q ? {{(DATA_WIDTH-8){1'b0}}, byte_lane}
                                      : {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = uns_q ? {{(DATA_WIDTH-16){1'b0}}, half_lane}
                                      : {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = dec_fault ? DONE : REQ;
            REQ:     if (mem_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured once in IDLE so the memory sees stable values for the whole REQ phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        fault_q <= dec_fault;
                        if (dec_fault) begin
                            rdata_q <= '0;
                        end else begin
                            addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            be_q    <= be_dec;
                            wdata_q <= wdata_dec;
                            we_q    <= req_we;
                            size_q  <= funct3[1:0];
                            uns_q   <= funct3[2];
                            off_q   <= addr[1:0];
                        end
                    end
                end
                REQ: begin
                    if (mem_ready && !we_q) rdata_q <= load_ext;
                end
                default: ;
            endcase
        end
    end

    // stall is forced low while reset is held so the core is never frozen by a reset mid-access.
    assign stall     = rst_n && (((state == IDLE) && req_valid) || (state == REQ));
    assign mem_req   = (state == REQ);
    assign mem_we    = (state == REQ) && we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign done      = (state == DONE);
    assign fault     = (state == DONE) && fault_q;
    assign rdata_out = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: hand-computed vectors for loads, stores, wait states,
// faults and reset during an access, with a simple memory driven directly from each test.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] rdata_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int num_checks;
    int num_fail;
    logic [31:0] exp_rdata;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .fault     (fault),
        .rdata_out (rdata_out),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every action happens 1ns after a rising edge, well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
    endtask

    task automatic retire();
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #12;
        num_checks++;
        if ({stall, done, fault, mem_req, mem_we} !== 5'b0) begin
            num_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {stall, done, fault, mem_req, mem_we});
        end
        num_checks++;
        if ({rdata_out, mem_addr, mem_be, mem_wdata} !== 100'b0) begin
            num_fail++;
            $display("[TB] FAIL reset_data: got %h %h %h %h expected all zero", rdata_out, mem_addr, mem_be, mem_wdata);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word_load();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        num_checks++;
        if (stall !== 1'b1 || mem_req !== 1'b0) begin
            num_fail++;
            $display("[TB] FAIL lw_cycle0: got stall=%b req=%b expected stall=1 req=0", stall, mem_req);
        end
        tick();
        num_checks++;
        if ({mem_req, mem_we, stall, done} !== 4'b1010 || mem_addr !== 32'h100 || mem_be !== 4'b1111) begin
            num_fail++;
            $display("[TB] FAIL lw_cycle1: got req/we/stall/done=%b addr=%h be=%b expected 1010 100 1111",
                     {mem_req, mem_we, stall, done}, mem_addr, mem_be);
        end
        tick();
        num_checks++;
        if ({done, fault, stall, mem_req} !== 4'b1000 || rdata_out !== 32'hDEADBEEF) begin
            num_fail++;
            $display("[TB] FAIL lw_done: got done/fault/stall/req=%b rdata=%h expected 1000 deadbeef",
                     {done, fault, stall, mem_req}, rdata_out);
        end
        retire();
        num_checks++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            num_fail++;
            $display("[TB] FAIL lw_after: got done=%b stall=%b expected 0 0", done, stall);
        end
        exp_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_byte_loads();
        logic [2:0]  f3s [2];
        logic [31:0] exps [2];
        f3s[0] = 3'b000; exps[0] = 32'hFFFFFF80;
        f3s[1] = 3'b100; exps[1] = 32'h00000080;
        mem_ready = 1'b1;
        mem_rdata = 32'h80123456;
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, f3s[i], 32'h103, 32'h0);
            tick();
            num_checks++;
            if (mem_be !== 4'b1000 || mem_addr !== 32'h100 || mem_req !== 1'b1) begin
                num_fail++;
                $display("[TB] FAIL lb_be[%0d]: got be=%b addr=%h req=%b expected 1000 100 1", i, mem_be, mem_addr, mem_req);
            end
            tick();
            num_checks++;
            if (done !== 1'b1 || rdata_out !== exps[i]) begin
                num_fail++;
                $display("[TB] FAIL lb_data[%0d]: got done=%b rdata=%h expected 1 %h", i, done, rdata_out, exps[i]);
            end
            retire();
        end
        exp_rdata = 32'h00000080;
    endtask

    task automatic test_store_half();
        mem_ready = 1'b1;
        mem_rdata = 32'h55555555;
        issue(1'b1, 3'b001, 32'h206, 32'h1234ABCD);
        tick();
        num_checks++;
        if (mem_addr !== 32'h204 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD || mem_we !== 1'b1) begin
            num_fail++;
            $display("[TB] FAIL sh_bus: got addr=%h be=%b wdata=%h we=%b expected 204 1100 abcdabcd 1",
                     mem_addr, mem_be, mem_wdata, mem_we);
        end
        tick();
        num_checks++;
        if (done !== 1'b1 || fault !== 1'b0 || rdata_out !== exp_rdata) begin
            num_fail++;
            $display("[TB] FAIL sh_done: got done=%b fault=%b rdata=%h expected 1 0 %h", done, fault, rdata_out, exp_rdata);
        end
        retire();
    endtask

    task automatic test_store_byte();
        mem_ready = 1'b1;
        issue(1'b1, 3'b000, 32'h101, 32'h0000005A);
        tick();
        num_checks++;
        if (mem_addr !== 32'h100 || mem_be !== 4'b0010 || mem_wdata !== 32'h5A5A5A5A || mem_we !== 1'b1) begin
            num_fail++;
            $display("[TB] FAIL sb_bus: got addr=%h be=%b wdata=%h we=%b expected 100 0010 5a5a5a5a 1",
                     mem_addr, mem_be, mem_wdata, mem_we);
        end
        tick();
        retire();
    endtask

    task automatic test_wait_states();
        int stall_cycles;
        int done_count;
        stall_cycles = 0;
        done_count   = 0;
        mem_ready = 1'b0;
        issue(1'b1, 3'b010, 32'h300, 32'hCAFEF00D);
        if (stall === 1'b1) stall_cycles++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (stall === 1'b1) stall_cycles++;
            if (done === 1'b1) done_count++;
            num_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h300 || mem_be !== 4'b1111 ||
                mem_wdata !== 32'hCAFEF00D) begin
                num_fail++;
                $display("[TB] FAIL sw_hold[%0d]: got req=%b we=%b addr=%h be=%b wdata=%h expected 1 1 300 1111 cafef00d",
                         i, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
            end
            if (i == 4) mem_ready = 1'b1;
        end
        for (int i = 5; i <= 7; i++) begin
            if (i == 5) tick();
            else retire();
            if (stall === 1'b1) stall_cycles++;
            if (done === 1'b1) done_count++;
        end
        num_checks++;
        if (stall_cycles != 5) begin
            num_fail++;
            $display("[TB] FAIL sw_stall_len: got %0d expected 5", stall_cycles);
        end
        num_checks++;
        if (done_count != 1) begin
            num_fail++;
            $display("[TB] FAIL sw_done_count: got %0d expected 1", done_count);
        end
    endtask

    task automatic test_faults();
        logic [2:0]  f3s [3];
        logic [31:0] addrs [3];
        logic        wes [3];
        f3s[0] = 3'b010; addrs[0] = 32'h102; wes[0] = 1'b0;
        f3s[1] = 3'b011; addrs[1] = 32'h100; wes[1] = 1'b0;
        f3s[2] = 3'b100; addrs[2] = 32'h100; wes[2] = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            // Seed a nonzero rdata_out so the fault's clear is observable.
            issue(1'b0, 3'b010, 32'h100, 32'h0);
            tick();
            tick();
            retire();
            issue(wes[i], f3s[i], addrs[i], 32'h0);
            tick();
            num_checks++;
            if ({mem_req, done, fault, stall} !== 4'b0110 || rdata_out !== 32'h0) begin
                num_fail++;
                $display("[TB] FAIL fault[%0d]: got req/done/fault/stall=%b rdata=%h expected 0110 00000000",
                         i, {mem_req, done, fault, stall}, rdata_out);
            end
            retire();
            num_checks++;
            if (fault !== 1'b0 || done !== 1'b0) begin
                num_fail++;
                $display("[TB] FAIL fault_pulse[%0d]: got fault=%b done=%b expected 0 0", i, fault, done);
            end
        end
    endtask

    task automatic test_half_loads();
        logic [2:0]  f3s [2];
        logic [31:0] addrs [2];
        logic [31:0] rds [2];
        logic [3:0]  bes [2];
        logic [31:0] exps [2];
        f3s[0] = 3'b001; addrs[0] = 32'h102; rds[0] = 32'h80017FFF; bes[0] = 4'b1100; exps[0] = 32'hFFFF8001;
        f3s[1] = 3'b101; addrs[1] = 32'h100; rds[1] = 32'h1234F00D; bes[1] = 4'b0011; exps[1] = 32'h0000F00D;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_rdata = rds[i];
            issue(1'b0, f3s[i], addrs[i], 32'h0);
            tick();
            num_checks++;
            if (mem_be !== bes[i]) begin
                num_fail++;
                $display("[TB] FAIL lh_be[%0d]: got %b expected %b", i, mem_be, bes[i]);
            end
            tick();
            num_checks++;
            if (rdata_out !== exps[i]) begin
                num_fail++;
                $display("[TB] FAIL lh_data[%0d]: got %h expected %h", i, rdata_out, exps[i]);
            end
            retire();
        end
    endtask

    task automatic test_reset_mid_access();
        int done_seen;
        int budget;
        done_seen = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        issue(1'b0, 3'b010, 32'h400, 32'h0);
        tick();
        num_checks++;
        if (mem_req !== 1'b1) begin
            num_fail++;
            $display("[TB] FAIL rst_pre: got req=%b expected 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        num_checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || rdata_out !== 32'h0) begin
            num_fail++;
            $display("[TB] FAIL rst_async: got req=%b stall=%b rdata=%h expected 0 0 00000000", mem_req, stall, rdata_out);
        end
        req_valid = 1'b0;
        mem_ready = 1'b1;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1 || mem_req === 1'b1) done_seen++;
        end
        num_checks++;
        if (done_seen != 0) begin
            num_fail++;
            $display("[TB] FAIL rst_late_ready: got %0d spurious cycles expected 0", done_seen);
        end
        mem_rdata = 32'h13579BDF;
        issue(1'b0, 3'b010, 32'h500, 32'h0);
        budget = 0;
        while (done !== 1'b1 && budget < 10) begin
            tick();
            budget++;
        end
        num_checks++;
        if (done !== 1'b1 || budget != 2 || rdata_out !== 32'h13579BDF) begin
            num_fail++;
            $display("[TB] FAIL rst_recover: got done=%b cycles=%0d rdata=%h expected 1 2 13579bdf", done, budget, rdata_out);
        end
        retire();
    endtask

    initial begin
        num_checks = 0;
        num_fail   = 0;
        exp_rdata  = 32'h0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        funct3     = 3'b010;
        addr       = 32'h0;
        wdata      = 32'h0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        test_reset();
        test_word_load();
        test_byte_loads();
        test_store_half();
        test_store_byte();
        test_wait_states();
        test_faults();
        test_half_loads();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
